// File: rtl/irq_encoder_32_pkg.sv
// irq_encoder_32_pkg: shared sizes and handshake state encodings for the interrupt encoder
package irq_encoder_32_pkg;
  localparam int NUM_SRC = 32;
  localparam int ID_W = 5;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/irq_encoder_32_prio_enc.sv
// prio_enc_32: combinational 32-to-5 lowest-index priority encoder with any-valid flag
module prio_enc_32
  import irq_encoder_32_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) id = req[i] ? ID_W'(i) : id;
  end
  assign valid = |req;
endmodule

// File: rtl/irq_encoder_32.sv
// irq_encoder_32: pending/mask storage and request/ack/eret handshake around a priority encoder
module irq_encoder_32
  import irq_encoder_32_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] IrqIn,
  input  logic               MaskWe,
  input  logic [NUM_SRC-1:0] MaskIn,
  output logic [NUM_SRC-1:0] MaskOut,
  output logic [NUM_SRC-1:0] PendOut,
  output logic               IrqValid,
  output logic [ID_W-1:0]    IrqId,
  input  logic               IrqAck,
  output logic               InService,
  input  logic               Eret
);
  logic [NUM_SRC-1:0] mask, pending, irqPrev, ackClr, active;
  logic [ID_W-1:0] encId, idReg;
  logic encValid;
  state_t state, nextState;
  assign active = pending & mask;
  prio_enc_32 uEnc (.req(active), .id(encId), .valid(encValid));
  assign ackClr = (state == REQ && IrqAck) ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << idReg) : '0;
  // a fresh rising edge on the acked bit is OR'd in after the clear, so set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      pending <= '0;
      irqPrev <= '0;
      state   <= IDLE;
      idReg   <= '0;
    end else begin
      mask    <= MaskWe ? MaskIn : mask;
      irqPrev <= IrqIn;
      pending <= EDGE_MODE ? ((pending & ~ackClr) | (IrqIn & ~irqPrev)) : IrqIn;
      state   <= nextState;
      idReg   <= (state == IDLE && encValid) ? encId : idReg;
    end
  end
  always_comb begin
    nextState = state == IDLE    ? (encValid ? REQ : IDLE) :
                state == REQ     ? (IrqAck ? SERVICE : REQ) :
                state == SERVICE ? (Eret ? IDLE : SERVICE) : IDLE;
  end
  always_comb begin
    IrqValid  = state == REQ;
    InService = state == SERVICE;
    IrqId     = idReg;
    MaskOut   = mask;
    PendOut   = pending;
  end
endmodule

// File: tb/tb_irq_encoder_32.sv
// tb_irq_encoder_32: directed vector table, corner sequences and randomized model comparison
module tb_irq_encoder_32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] irqIn = '0, maskIn = '0, maskOut, pendOut;
  logic maskWe = 1'b0, irqAck = 1'b0, eret = 1'b0, irqValid, inService;
  logic [4:0] irqId;
  int checks = 0, errors = 0;

  irq_encoder_32 dut (
    .clk(clk), .rst_n(rst_n), .IrqIn(irqIn), .MaskWe(maskWe), .MaskIn(maskIn),
    .MaskOut(maskOut), .PendOut(pendOut), .IrqValid(irqValid), .IrqId(irqId),
    .IrqAck(irqAck), .InService(inService), .Eret(eret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] irq;
    logic        mwe;
    logic [31:0] min;
    logic        ack;
    logic        ret;
    logic        eValid;
    logic [4:0]  eId;
    logic        eSvc;
    logic [31:0] ePend;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] mPend, mMask, mPrev;
  int mState;
  logic [4:0] mId;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] irq, input logic mwe, input logic [31:0] min,
                       input logic ack, input logic ret);
    irqIn = irq; maskWe = mwe; maskIn = min; irqAck = ack; eret = ret;
  endtask

  task automatic doReset();
    drive('0, 0, '0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mPend = '0; mMask = '0; mPrev = '0; mState = 0; mId = '0;
  endtask

  // reference: one clock of the handshake, derived from the behavioural rules
  task automatic modelStep();
    logic [31:0] np;
    int winner;
    np = mPend;
    if (mState == 1 && irqAck) np[mId] = 1'b0;
    for (int i = 0; i < 32; i++) if (irqIn[i] && !mPrev[i]) np[i] = 1'b1;
    winner = -1;
    for (int i = 31; i >= 0; i--) if (mPend[i] && mMask[i]) winner = i;
    if (mState == 0 && winner >= 0) begin mState = 1; mId = 5'(winner); end
    else if (mState == 1 && irqAck) mState = 2;
    else if (mState == 2 && eret) mState = 0;
    mPend = np;
    if (maskWe) mMask = maskIn;
    mPrev = irqIn;
  endtask

  initial begin
    // reset held with every line high and no mask
    drive('1, 0, '0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_valid", 32'(irqValid), 0);
      check("rst_svc", 32'(inService), 0);
      check("rst_mask", maskOut, 0);
      check("rst_pend", pendOut, 0);
    end
    irqIn = '0;
    tick();
    rst_n = 1'b1;

    vecs.push_back('{32'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h80, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h80});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd7, 0, 32'h80});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h0});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h100008, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h100008});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd3, 0, 32'h100008});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h100000});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h100000});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd20, 0, 32'h100000});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h0});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h0, 1, 32'h1, 0, 0, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h20, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h20});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h20});
    vecs.push_back('{32'h0, 1, 32'h20, 0, 0, 0, 5'd0, 0, 32'h20});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd5, 0, 32'h20});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h0});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h0, 1, 32'hFFFFFFFF, 1, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h200, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h200});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd9, 0, 32'h200});
    vecs.push_back('{32'h200, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h200});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h200});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd9, 0, 32'h200});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h0});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h10, 0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h10});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 1, 5'd4, 0, 32'h10});
    vecs.push_back('{32'h0, 1, 32'h0, 0, 0, 1, 5'd4, 0, 32'h10});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 0, 1, 5'd4, 0, 32'h10});
    vecs.push_back('{32'h0, 0, 32'h0, 1, 0, 0, 5'd0, 1, 32'h0});
    vecs.push_back('{32'h0, 0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0});
    vecs.push_back('{32'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 5'd0, 0, 32'h0});
    foreach (vecs[v]) begin
      drive(vecs[v].irq, vecs[v].mwe, vecs[v].min, vecs[v].ack, vecs[v].ret);
      tick();
      check($sformatf("vec%0d_valid", v), 32'(irqValid), 32'(vecs[v].eValid));
      check($sformatf("vec%0d_svc", v), 32'(inService), 32'(vecs[v].eSvc));
      check($sformatf("vec%0d_pend", v), pendOut, vecs[v].ePend);
      if (vecs[v].eValid) check($sformatf("vec%0d_id", v), 32'(irqId), 32'(vecs[v].eId));
    end
    check("tbl_mask", maskOut, 32'hFFFFFFFF);

    // every source pending at once: served strictly in index order
    drive('1, 0, '0, 0, 0);
    tick();
    check("all_pend", pendOut, 32'hFFFFFFFF);
    drive('0, 0, '0, 0, 0);
    tick();
    for (int n = 0; n < 32; n++) begin
      check($sformatf("all_valid%0d", n), 32'(irqValid), 1);
      check($sformatf("all_id%0d", n), 32'(irqId), n);
      drive('0, 0, '0, 1, 0);
      tick();
      check($sformatf("all_svc%0d", n), 32'(inService), 1);
      drive('0, 0, '0, 0, 1);
      tick();
      drive('0, 0, '0, 0, 0);
      tick();
    end
    check("all_done_valid", 32'(irqValid), 0);
    check("all_done_pend", pendOut, 0);

    // async reset in REQ clears outputs before the next edge
    drive(32'h3000, 0, '0, 0, 0);
    tick();
    drive('0, 0, '0, 0, 0);
    tick();
    check("ar_valid_pre", 32'(irqValid), 1);
    check("ar_id_pre", 32'(irqId), 12);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(irqValid), 0);
    check("ar_id", 32'(irqId), 0);
    check("ar_pend", pendOut, 0);
    check("ar_mask", maskOut, 0);

    // randomized traffic against the reference model
    doReset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom & $urandom & $urandom, ($urandom_range(0, 7) == 0),
            $urandom | $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      modelStep();
      tick();
      check("rnd_pend", pendOut, mPend);
      check("rnd_mask", maskOut, mMask);
      check("rnd_valid", 32'(irqValid), 32'(mState == 1));
      check("rnd_svc", 32'(inService), 32'(mState == 2));
      if (mState != 0) check("rnd_id", 32'(irqId), 32'(mId));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_encoder_32.md
Name: irq_encoder_32

Overview:
- Collects 32 single-bit interrupt request lines and encodes the highest-priority enabled pending source into a 5-bit ID for the CPU core.
- Functionally the inverse of the 5-bit-select to 32-line demultiplexer used on the register-file write-enable path: it turns 32 lines back into an index, but adds pending storage, masking and a request/ack/return handshake.
- Sits between peripheral IRQ lines and the single-cycle CPU's trap logic.

Parameters:
- NUM_SRC, 32, number of request lines (fixed at 32 in this revision).
- ID_W, 5, width of encoded ID (log2 NUM_SRC).
- EDGE_MODE, 1, 1 = rising-edge latched pending bits; 0 = level-sensitive.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- IrqIn  input  32  request lines, synchronous to clk
- MaskWe  input  1  load MaskIn into mask register this cycle
- MaskIn  input  32  new enable mask (bit=1 enables source)
- MaskOut  output  32  current mask register
- PendOut  output  32  current pending register
- IrqValid  output  1  interrupt request to core (registered)
- IrqId  output  5  encoded source ID, valid while IrqValid=1
- IrqAck  input  1  core accepts request (one-cycle pulse)
- InService  output  1  handler running
- Eret  input  1  core returns from handler (one-cycle pulse)

Behaviour:
- Reset (async, rst_n=0): mask=0, pending=0, irq_prev=0, state=IDLE, IrqValid=0, IrqId=0, InService=0. Reset mid-handshake aborts it immediately; there is no recovery of in-flight IDs.
- Edge mode: pending[i] is set when IrqIn[i]=1 and irq_prev[i]=0 at a clock edge. irq_prev is IrqIn registered every cycle.
- Level mode: pending is IrqIn registered each cycle, and IrqAck does not clear it. The source must drop its request before Eret, otherwise the request re-fires.
- Priority: lowest index wins. Encoder input is pending & mask.
- FSM IDLE: if (pending & mask)!=0, latch encoded ID into IrqId, go to REQ, and set IrqValid=1 (registered). Latency: an edge sampled at clock k produces pending at k and IrqValid/IrqId at k+1.
- FSM REQ: IrqId and IrqValid are held stable regardless of new pendings or mask writes. On IrqAck: clear pending[IrqId] (edge mode), IrqValid=0, InService=1, go to SERVICE.
- FSM SERVICE: IrqId is held. On Eret: InService=0, go to IDLE. A new request may then be raised the next cycle, with no dead cycle beyond the IDLE evaluation.
- No nesting: pendings accumulate during SERVICE.
- IrqAck outside REQ is ignored. Eret outside SERVICE is ignored.
- Simultaneous new edge and ack-clear on the same bit: set wins, and the bit stays pending.
- MaskWe is honoured in every state and takes effect the next cycle. A mask write that disables the source currently in REQ does not withdraw it.
- All sources pending: ID 0 is served first, then 1, and so on. Source 31 is served only when 0..30 are clear or masked.

Decomposition:
- Shared package holds NUM_SRC, ID_W, and the state encodings IDLE=2'd0, REQ=2'd1, SERVICE=2'd2 (2'd3 is illegal and recovers to IDLE).
- One sub-module, prio_enc_32: combinational 32-to-5 lowest-index encoder with an any-valid output. It is reusable elsewhere in the datapath.

Test Plan:
- Reset with IrqIn=all ones, mask=0 → IrqValid=0, InService=0, MaskOut=0 throughout. Release reset → PendOut=0xFFFFFFFF only if edges occur after reset.
- Mask=0xFFFFFFFF, pulse IrqIn[7] at cycle k → PendOut[7]=1 at k, IrqValid=1 with IrqId=7 at k+1. IrqAck → PendOut[7]=0, InService=1. Eret → InService=0, state IDLE.
- IrqIn[3] and IrqIn[20] rising together → IrqId=3 first. After ack+Eret, IrqId=20 is presented one cycle later.
- Mask=0x00000001, pulse IrqIn[5] → no IrqValid and PendOut[5]=1. Write mask=0x20 → IrqValid with IrqId=5 two cycles after MaskWe.
- New IrqIn[9] edge in the same cycle as IrqAck for ID 9 → PendOut[9] stays 1, and ID 9 is re-requested after Eret.
- Assert rst_n=0 while in REQ with IrqId=12 → IrqValid, IrqId and PendOut clear asynchronously, before the next clk edge.
